// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the fetch PC and keeps one request in flight to instruction memory.
// Returned words go into the IF/ID register, or into a one-entry skid buffer while ID is stalled.
module instr_fetch_unit #(
  parameter int                ADDR_W   = 32,
  parameter int                DATA_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] next_address,
  input  logic              redirect,
  input  logic              stall,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_gnt,
  input  logic              imem_rvalid,
  input  logic [DATA_W-1:0] imem_rdata,
  output logic [ADDR_W-1:0] pc_out,
  output logic [DATA_W-1:0] instr_out,
  output logic              instr_valid
);

  typedef enum logic [1:0] {
    S_FETCH = 2'd0,
    S_WAIT  = 2'd1,
    S_HOLD  = 2'd2
  } state_e;

  state_e            state_q;
  logic [ADDR_W-1:0] fetch_pc_q;
  logic              discard_q;
  logic [ADDR_W-1:0] skid_pc_q;
  logic [DATA_W-1:0] skid_word_q;
  logic              skid_full_q;
  logic [ADDR_W-1:0] pc_out_q;
  logic [DATA_W-1:0] instr_out_q;
  logic              instr_valid_q;

  logic [ADDR_W-1:0] fetch_pc_inc_d;
  assign fetch_pc_inc_d = fetch_pc_q + {{(ADDR_W-1){1'b0}}, 1'b1};

  // Request is decoded from state so it rises on the first cycle after reset release.
  assign imem_req    = reset && (state_q == S_FETCH);
  assign imem_addr   = fetch_pc_q;
  assign pc_out      = pc_out_q;
  assign instr_out   = instr_out_q;
  assign instr_valid = instr_valid_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= S_FETCH;
      fetch_pc_q    <= RESET_PC;
      discard_q     <= 1'b0;
      skid_pc_q     <= '0;
      skid_word_q   <= '0;
      skid_full_q   <= 1'b0;
      pc_out_q      <= '0;
      instr_out_q   <= '0;
      instr_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_FETCH: begin
          if (redirect) begin
            fetch_pc_q    <= next_address;
            instr_valid_q <= 1'b0;
            skid_full_q   <= 1'b0;
            // The old address was already accepted; its data must be thrown away.
            if (imem_gnt) begin
              discard_q <= 1'b1;
              state_q   <= S_WAIT;
            end
          end else begin
            if (!stall) instr_valid_q <= 1'b0;
            if (imem_gnt) state_q <= S_WAIT;
          end
        end

        S_WAIT: begin
          if (redirect) begin
            fetch_pc_q    <= next_address;
            instr_valid_q <= 1'b0;
            skid_full_q   <= 1'b0;
            if (imem_rvalid) begin
              discard_q <= 1'b0;
              state_q   <= S_FETCH;
            end else begin
              discard_q <= 1'b1;
            end
          end else if (imem_rvalid && discard_q) begin
            discard_q <= 1'b0;
            state_q   <= S_FETCH;
            if (!stall) instr_valid_q <= 1'b0;
          end else if (imem_rvalid && (!instr_valid_q || !stall)) begin
            pc_out_q      <= fetch_pc_q;
            instr_out_q   <= imem_rdata;
            instr_valid_q <= 1'b1;
            fetch_pc_q    <= fetch_pc_inc_d;
            state_q       <= S_FETCH;
          end else if (imem_rvalid) begin
            skid_pc_q   <= fetch_pc_q;
            skid_word_q <= imem_rdata;
            skid_full_q <= 1'b1;
            fetch_pc_q  <= fetch_pc_inc_d;
            state_q     <= S_HOLD;
          end else if (!stall) begin
            instr_valid_q <= 1'b0;
          end
        end

        S_HOLD: begin
          if (redirect) begin
            fetch_pc_q    <= next_address;
            instr_valid_q <= 1'b0;
            skid_full_q   <= 1'b0;
            state_q       <= S_FETCH;
          end else if (!stall && skid_full_q) begin
            pc_out_q      <= skid_pc_q;
            instr_out_q   <= skid_word_q;
            instr_valid_q <= 1'b1;
            skid_full_q   <= 1'b0;
            state_q       <= S_FETCH;
          end
        end

        default: state_q <= S_FETCH;
      endcase
    end
  end

endmodule
